// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
// One request outstanding at a time; ack may arrive in the same cycle as req.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: issues imem reads, holds the result in IF/ID with a one-entry skid.
// Optional macro FETCH_MISALIGN_TRAP_EN turns misaligned pcs into NOP entries tagged id_misalign.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     i_pc_in,
  output logic            o_pc_advance,
  input  logic            i_flush,
  if_fetch_unit_if.master imem,
  input  logic            i_id_stall,
  output logic            o_id_valid,
  output logic [31:0]     o_id_pc,
  output logic [31:0]     o_id_insn
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            o_id_misalign
`endif
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_drop;
  logic [31:0] r_req_addr;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_insn;
  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_insn;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        r_skid_mis;
  logic        r_id_mis;
`endif

  logic        w_requesting;
  logic        w_misalign;
  logic        w_ack;
  logic        w_accept;
  logic        w_slot_free;
  logic [31:0] w_addr;
  logic [31:0] w_data;

  always_comb begin
    // NOTE: every signal gets a value on every path through this block so no latch is inferred.
    w_requesting = (r_state != S_FULL) && !reset;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_misalign   = (r_state == S_ISSUE) && (i_pc_in[1:0] != 2'b00);
`else
    w_misalign   = 1'b0;
`endif
    w_addr       = (r_state == S_ISSUE) ? i_pc_in : r_req_addr;
    // A misaligned entry completes at once, as if memory had acked a NOP.
    w_ack        = w_requesting && (w_misalign || imem.imem_ack);
    w_accept     = w_ack && !i_flush && !r_drop;
    w_data       = w_misalign ? NOP_INSN : imem.imem_rdata;
    w_slot_free  = !r_id_valid || !i_id_stall;
  end

  assign imem.imem_req  = w_requesting && !w_misalign;
  assign imem.imem_addr = w_addr;
  assign o_pc_advance   = w_accept;
  assign o_id_valid     = r_id_valid;
  assign o_id_pc        = r_id_pc;
  assign o_id_insn      = r_id_insn;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign o_id_misalign  = r_id_mis;
`endif

  // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_ISSUE;
      r_drop      <= 1'b0;
      r_req_addr  <= 32'h0;
      r_skid_pc   <= 32'h0;
      r_skid_insn <= NOP_INSN;
      r_id_valid  <= 1'b0;
      r_id_pc     <= RESET_PC;
      r_id_insn   <= NOP_INSN;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_skid_mis  <= 1'b0;
      r_id_mis    <= 1'b0;
`endif
    end else if (i_flush) begin
      r_id_valid  <= 1'b0;
      r_id_insn   <= NOP_INSN;
      r_skid_pc   <= 32'h0;
      r_skid_insn <= NOP_INSN;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_skid_mis  <= 1'b0;
      r_id_mis    <= 1'b0;
`endif
      // A request already on the bus cannot be withdrawn: wait out its ack and discard it.
      if (r_state != S_FULL && !w_ack) begin
        r_drop  <= 1'b1;
        r_state <= S_WAIT;
        if (r_state == S_ISSUE) r_req_addr <= i_pc_in;
      end else begin
        r_drop  <= 1'b0;
        r_state <= S_ISSUE;
      end
    end else begin
      if (r_id_valid && !i_id_stall) r_id_valid <= 1'b0;
      case (r_state)
        S_ISSUE, S_WAIT: begin
          if (r_state == S_ISSUE) r_req_addr <= i_pc_in;
          if (w_ack) begin
            r_drop  <= 1'b0;
            r_state <= S_ISSUE;
            if (w_accept) begin
              if (w_slot_free) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= w_addr;
                r_id_insn  <= w_data;
`ifdef FETCH_MISALIGN_TRAP_EN
                r_id_mis   <= w_misalign;
`endif
              end else begin
                r_skid_pc   <= w_addr;
                r_skid_insn <= w_data;
`ifdef FETCH_MISALIGN_TRAP_EN
                r_skid_mis  <= w_misalign;
`endif
                r_state     <= S_FULL;
              end
            end
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_FULL: begin
          if (w_slot_free) begin
            r_id_valid  <= 1'b1;
            r_id_pc     <= r_skid_pc;
            r_id_insn   <= r_skid_insn;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_id_mis    <= r_skid_mis;
            r_skid_mis  <= 1'b0;
`endif
            r_skid_pc   <= 32'h0;
            r_skid_insn <= NOP_INSN;
            r_state     <= S_ISSUE;
          end
        end
        default: r_state <= S_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, corner sequences, random vs. reference model.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0100_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] MASK     = 32'hFFFF_0000;
  localparam logic [31:0] B        = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_insn;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        id_misalign;
`endif

  if_fetch_unit_if imem ();

  if_fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .i_pc_in      (pc_in),
    .o_pc_advance (pc_advance),
    .i_flush      (flush),
    .imem         (imem),
    .i_id_stall   (id_stall),
    .o_id_valid   (id_valid),
    .o_id_pc      (id_pc),
    .o_id_insn    (id_insn)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .o_id_misalign(id_misalign)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply decode/flush inputs, then let memory answer whatever request is on the bus.
  task automatic drive(input logic st, input logic fl, input logic ack_want);
    id_stall = st;
    flush    = fl;
    #1;
    imem.imem_ack   = ack_want && imem.imem_req;
    imem.imem_rdata = imem.imem_ack ? (imem.imem_addr ^ MASK) : 32'hDEAD_BEEF;
    #1;
  endtask

  // Clock edge plus the PC generator: load target on flush, else step by 4 on pc_advance.
  task automatic advance(input logic fl, input logic [31:0] tgt);
    logic adv;
    adv = pc_advance;
    @(posedge clock);
    #1;
    if (fl)       pc_in = tgt;
    else if (adv) pc_in = pc_in + 32'd4;
    flush         = 1'b0;
    imem.imem_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pc_in = RESET_PC;
    flush = 1'b0;
    id_stall = 1'b0;
    imem.imem_ack = 1'b0;
    imem.imem_rdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        st, fl, ack;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_adv;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_nop;
  } vec_t;

  function automatic vec_t mk(logic st, logic fl, logic ack, logic [31:0] tgt,
                              logic e_req, logic [31:0] e_addr, logic e_adv,
                              logic e_valid, logic [31:0] e_pc, logic e_nop);
    vec_t v;
    v.st = st; v.fl = fl; v.ack = ack; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_adv = e_adv;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_nop = e_nop;
    return v;
  endfunction

  // Reference model: outstanding request, pending-entry queue, IF/ID slot.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } entry_t;

  entry_t      skid_q[$];
  logic        m_out, m_drop, m_valid;
  logic [31:0] m_addr, m_pc, m_insn;

  vec_t tbl[$];

  initial begin
    // ---------------- reset state ----------------
    reset = 1'b1;
    pc_in = RESET_PC;
    flush = 1'b0;
    id_stall = 1'b0;
    imem.imem_ack = 1'b0;
    imem.imem_rdata = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_low", imem.imem_req, 1'b0);
    check("rst_adv_low", pc_advance, 1'b0);
    check("rst_valid", id_valid, 1'b0);
    check("rst_pc", id_pc, RESET_PC);
    check("rst_insn", id_insn, NOP);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_misalign", id_misalign, 1'b0);
`endif
    reset = 1'b0;
    #1;

    // ---------------- directed vector table ----------------
    tbl.push_back(mk(0,0,1,0,         1,B+32'h000,1, 1,B+32'h000,0));
    tbl.push_back(mk(0,0,0,0,         1,B+32'h004,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,         1,B+32'h004,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,         1,B+32'h004,0, 0,0,0));
    tbl.push_back(mk(0,0,1,0,         1,B+32'h004,1, 1,B+32'h004,0));
    tbl.push_back(mk(1,0,1,0,         1,B+32'h008,1, 1,B+32'h004,0));
    tbl.push_back(mk(1,0,0,0,         0,0,0,         1,B+32'h004,0));
    tbl.push_back(mk(0,0,0,0,         0,0,0,         1,B+32'h008,0));
    tbl.push_back(mk(0,0,0,0,         1,B+32'h00C,0, 0,0,0));
    tbl.push_back(mk(0,1,0,B+32'h100, 1,B+32'h00C,0, 0,0,1));
    tbl.push_back(mk(0,0,0,0,         1,B+32'h00C,0, 0,0,1));
    tbl.push_back(mk(0,0,1,0,         1,B+32'h00C,0, 0,0,1));
    tbl.push_back(mk(0,0,1,0,         1,B+32'h100,1, 1,B+32'h100,0));
    tbl.push_back(mk(0,1,1,B+32'h200, 1,B+32'h104,0, 0,0,1));
    tbl.push_back(mk(0,0,1,0,         1,B+32'h200,1, 1,B+32'h200,0));
    tbl.push_back(mk(1,0,1,0,         1,B+32'h204,1, 1,B+32'h200,0));
    tbl.push_back(mk(1,1,0,B+32'h300, 0,0,0,         0,0,1));
    tbl.push_back(mk(0,0,1,0,         1,B+32'h300,1, 1,B+32'h300,0));
    tbl.push_back(mk(0,1,0,B+32'h400, 1,B+32'h304,0, 0,0,1));
    tbl.push_back(mk(0,0,1,0,         1,B+32'h304,0, 0,0,1));
    tbl.push_back(mk(0,0,1,0,         1,B+32'h400,1, 1,B+32'h400,0));

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].fl, tbl[i].ack);
      check($sformatf("vec%0d_req", i), imem.imem_req, tbl[i].e_req);
      if (tbl[i].e_req) check($sformatf("vec%0d_addr", i), imem.imem_addr, tbl[i].e_addr);
      check($sformatf("vec%0d_adv", i), pc_advance, tbl[i].e_adv);
      advance(tbl[i].fl, tbl[i].tgt);
      check($sformatf("vec%0d_valid", i), id_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        check($sformatf("vec%0d_pc", i), id_pc, tbl[i].e_pc);
        check($sformatf("vec%0d_insn", i), id_insn, tbl[i].e_pc ^ MASK);
      end else if (tbl[i].e_nop) begin
        check($sformatf("vec%0d_nop", i), id_insn, NOP);
      end
    end

    // ---------------- reset while a request is outstanding ----------------
    drive(0, 0, 0);
    check("midrst_req_before", imem.imem_req, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_req_dropped", imem.imem_req, 1'b0);
    check("midrst_no_adv", pc_advance, 1'b0);
    @(posedge clock);
    #1;
    pc_in = RESET_PC;
    check("midrst_valid", id_valid, 1'b0);
    check("midrst_pc", id_pc, RESET_PC);
    check("midrst_insn", id_insn, NOP);
    reset = 1'b0;
    #1;
    check("midrst_reissue_req", imem.imem_req, 1'b1);
    check("midrst_reissue_addr", imem.imem_addr, RESET_PC);

    // ---------------- redirect to a misaligned pc ----------------
    drive(0, 1, 1);
    check("mis_flush_adv", pc_advance, 1'b0);
    advance(1'b1, B + 32'h102);
    drive(0, 0, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_no_req", imem.imem_req, 1'b0);
    check("mis_adv", pc_advance, 1'b1);
    advance(1'b0, 32'h0);
    check("mis_valid", id_valid, 1'b1);
    check("mis_flag", id_misalign, 1'b1);
    check("mis_insn", id_insn, NOP);
    check("mis_pc", id_pc, B + 32'h102);
`else
    check("mis_req", imem.imem_req, 1'b1);
    check("mis_addr_unmodified", imem.imem_addr, B + 32'h102);
    check("mis_adv", pc_advance, 1'b1);
    advance(1'b0, 32'h0);
    check("mis_valid", id_valid, 1'b1);
    check("mis_pc", id_pc, B + 32'h102);
    check("mis_insn", id_insn, (B + 32'h102) ^ MASK);
`endif

    // ---------------- randomized run against the reference model ----------------
    do_reset();
    skid_q.delete();
    m_out = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
    m_addr = 32'h0; m_pc = RESET_PC; m_insn = NOP;

    for (int n = 0; n < 3000; n++) begin
      logic        st, fl, want, e_req, e_adv, sf, loaded, ack;
      logic [31:0] tgt, e_addr;
      entry_t      e;
      st   = ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 15) == 0);
      want = ($urandom_range(0, 2) != 0);
      tgt  = $urandom & 32'hFFFF_FFFC;
      drive(st, fl, want);
      ack = imem.imem_ack;

      e_req  = (skid_q.size() == 0);
      e_addr = m_out ? m_addr : pc_in;
      sf     = !m_valid || !st;
      e_adv  = e_req && ack && !fl && !m_drop;
      check("rnd_req", imem.imem_req, e_req);
      if (e_req) check("rnd_addr", imem.imem_addr, e_addr);
      check("rnd_adv", pc_advance, e_adv);

      if (fl) begin
        m_valid = 1'b0;
        m_insn  = NOP;
        skid_q.delete();
        if (e_req && !ack) begin
          m_out = 1'b1; m_addr = e_addr; m_drop = 1'b1;
        end else begin
          m_out = 1'b0; m_drop = 1'b0;
        end
      end else begin
        loaded = 1'b0;
        e.pc   = e_addr;
        e.insn = e_addr ^ MASK;
        if (e_req && ack) begin
          m_out = 1'b0;
          m_drop = 1'b0;
          if (e_adv) begin
            if (sf) loaded = 1'b1;
            else    skid_q.push_back(e);
          end
        end else if (e_req) begin
          m_out = 1'b1;
          m_addr = e_addr;
        end else if (sf) begin
          e = skid_q.pop_front();
          loaded = 1'b1;
        end
        if (loaded) begin
          m_valid = 1'b1; m_pc = e.pc; m_insn = e.insn;
        end else if (m_valid && !st) begin
          m_valid = 1'b0;
        end
      end

      advance(fl, tgt);
      check("rnd_valid", id_valid, m_valid);
      if (m_valid) begin
        check("rnd_pc", id_pc, m_pc);
        check("rnd_insn", id_insn, m_insn);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end that consumes the program counter from the PC generator and fetches from instruction memory over a req/ack handshake.
- Holds the fetched word in the IF/ID register for decode.
- Drives pc_advance back to the PC generator; the PC generator steps pc by 4 on the same edge as pc_advance.
- Sits between the PC generator, instruction memory and the decode stage. Handles decode stall and pipeline flush on branch/jump redirect.

Parameters:
- RESET_PC, 32'h01000000, value of id_pc at reset.
- NOP_INSN, 32'h00000013, value of id_insn at reset and after flush (addi x0,x0,0).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- pc_in  in  32  current pc from the PC generator
- pc_advance  out  1  combinational one-cycle pulse: fetch accepted, PC generator does pc+4 on this edge
- flush  in  1  redirect this cycle; the PC generator loads the target on the same edge
- imem_req  out  1  memory read request
- imem_addr  out  32  read address
- imem_ack  in  1  read data valid; allowed in the same cycle as the request
- imem_rdata  in  32  read data, sampled when imem_ack=1
- id_stall  in  1  decode cannot accept a new instruction
- id_valid  out  1  IF/ID register holds a live instruction
- id_pc  out  32  pc of the instruction in IF/ID
- id_insn  out  32  instruction in IF/ID

Behaviour:
- **Reset:** state=ISSUE, id_valid=0, id_pc=RESET_PC, id_insn=NOP_INSN, drop=0, skid empty, req_addr=0. A request is issued in the first cycle after reset deasserts.
- **States:**
  - ISSUE: imem_req=1, imem_addr=pc_in; req_addr<=pc_in.
  - WAIT: imem_req=1, imem_addr=req_addr. imem_addr stays stable until ack.
  - FULL: imem_req=0; skid buffer (pc, insn) is occupied.
- **Slot free:** slot_free = !id_valid || !id_stall.
- **Accept:** imem_ack=1 in ISSUE/WAIT, flush=0, drop=0.
  - If slot_free: id_pc<=address, id_insn<=imem_rdata, id_valid<=1, pc_advance=1, next state ISSUE.
  - Else: load skid, pc_advance=1, next state FULL.
- **No ack:** ISSUE→WAIT; WAIT stays in WAIT.
- **FULL:** on slot_free, move skid into IF/ID (id_valid<=1), clear skid, next state ISSUE. pc_advance=0 in FULL.
- **Decode consumption:** id_valid=1 and id_stall=0 with no new data gives id_valid<=0 next cycle.
- **Flush (highest priority):**
  - id_valid<=0, id_insn<=NOP_INSN, skid cleared, pc_advance=0.
  - Ack in the same cycle: data discarded, next state ISSUE.
  - Request outstanding without ack: drop<=1, stay WAIT with the old address held. The ack clearing drop is discarded with pc_advance=0, next state ISSUE.
  - In FULL: next state ISSUE.
- **Request protocol:** a request is never withdrawn before its ack; at most one request outstanding.
- **Throughput:** zero-wait memory gives 1 instruction/cycle. The address is pc_in+4 on the cycle after each accept.
- **Wrap:** pc arithmetic wraps at 2^32 in the PC generator; no special handling here.
- **Reset mid-transaction:** the outstanding request is abandoned; memory must tolerate req dropping on reset.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- **Defined:** adds output id_misalign (1 bit, reset 0). In ISSUE with pc_in[1:0]!=0, no imem_req is raised. The unit behaves as an immediate ack with insn=NOP_INSN and id_misalign=1 on that entry; pc_advance is still pulsed. id_misalign follows the entry through the skid buffer.
- **Not defined:** no port; pc_in[1:0] is ignored and the address goes to memory unmodified.

Test Plan:
- Reset, then zero-wait memory returning addr^32'hFFFF0000 -> imem_addr 0x01000000, 0x01000004, 0x01000008 on consecutive cycles. pc_advance high every cycle. id_pc lags imem_addr by one cycle.
- Ack delayed 3 cycles at 0x01000004 -> imem_req high 4 cycles, imem_addr stable, single pc_advance pulse in the ack cycle, id_valid=0 until the next edge.
- id_stall=1 while id_valid=1 and ack arrives for 0x01000008 -> FULL, no new imem_req. Release stall -> id_pc=0x01000008 next cycle, then request 0x0100000C.
- flush in WAIT (ack 2 cycles later), PC generator redirected to 0x01000100 -> late data discarded, id_valid stays 0, pc_advance=0, next imem_addr=0x01000100.
- flush and imem_ack in the same cycle -> data discarded, id_valid=0, id_insn=0x00000013, no pc_advance.
- With FETCH_MISALIGN_TRAP_EN and redirect to 0x01000102 -> no imem_req, id_misalign=1, id_insn=0x00000013, id_pc=0x01000102.
